axi_wr_arbiter: RTL and testbench

Two-master to one-slave AXI3 write-path arbiter for the AXI UVC environment. It grants the AW channel round-robin and locks the W channel to the granted master until `wlast`. It tags the slave-side ID with the master index and routes B responses back by that tag. It sits between two AXI write masters (VIP or DUT) and a single slave port, and flags beat-count/`wlast` mismatches.

---
 rtl/axi_wr_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI3 write arbiter: round-robin AW grant, W locked to grantee, ID-tagged B routing.
// Latency: AW grant combinational in IDLE, s_awvalid the next cycle; W and B paths are zero-latency pass-through.
// Backpressure: AW held stable until s_awready; W stalls follow s_wready; B stalls follow the addressed master's bready.
module axi_wr_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    aclk,
  input  logic                    arst,

  // master-side AW channels (master 0 in the low slice)
  input  logic [1:0]              m_awvalid,
  output logic [1:0]              m_awready,
  input  logic [2*ID_W-1:0]       m_awid,
  input  logic [2*ADDR_W-1:0]     m_awaddr,
  input  logic [7:0]              m_awlen,
  input  logic [5:0]              m_awsize,
  input  logic [3:0]              m_awburst,

  // master-side W channels
  input  logic [1:0]              m_wvalid,
  output logic [1:0]              m_wready,
  input  logic [2*DATA_W-1:0]     m_wdata,
  input  logic [2*DATA_W/8-1:0]   m_wstrb,
  input  logic [1:0]              m_wlast,

  // master-side B channels (payload broadcast)
  output logic [1:0]              m_bvalid,
  input  logic [1:0]              m_bready,
  output logic [ID_W-1:0]         m_bid,
  output logic [1:0]              m_bresp,

  // slave-side AW channel
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [ID_W:0]           s_awid,
  output logic [ADDR_W-1:0]       s_awaddr,
  output logic [3:0]              s_awlen,
  output logic [2:0]              s_awsize,
  output logic [1:0]              s_awburst,

  // slave-side W channel
  output logic                    s_wvalid,
  input  logic                    s_wready,
  output logic [DATA_W-1:0]       s_wdata,
  output logic [DATA_W/8-1:0]     s_wstrb,
  output logic                    s_wlast,

  // slave-side B channel
  input  logic                    s_bvalid,
  output logic                    s_bready,
  input  logic [ID_W:0]           s_bid,
  input  logic [1:0]              s_bresp,

  output logic                    proto_err
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              last_gnt;     // master granted most recently
  logic              gnt;          // master owning the current AW/W transaction
  logic [3:0]        cnt;          // W beats accepted so far in this transaction
  logic [3:0]        len;          // awlen of the current transaction
  logic              err;

  logic [ID_W:0]     aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;

  logic              aw_grant;
  logic              aw_sel;
  logic              aw_other;
  logic              w_hs;
  logic              w_last_sel;

  logic [ID_W-1:0]   sel_awid;
  logic [ADDR_W-1:0] sel_awaddr;
  logic [3:0]        sel_awlen;
  logic [2:0]        sel_awsize;
  logic [1:0]        sel_awburst;

  logic              b_sel;

  // Round-robin pick: prefer the master that did not win last time, else whoever is asking.
  always_comb begin
    aw_other = ~last_gnt;
    aw_sel   = m_awvalid[aw_other] ? aw_other : last_gnt;
    aw_grant = (state == IDLE) && (|m_awvalid);
  end

  // Select the AW payload of the master about to be granted.
  always_comb begin
    if (aw_sel) begin
      sel_awid    = m_awid[2*ID_W-1:ID_W];
      sel_awaddr  = m_awaddr[2*ADDR_W-1:ADDR_W];
      sel_awlen   = m_awlen[7:4];
      sel_awsize  = m_awsize[5:3];
      sel_awburst = m_awburst[3:2];
    end else begin
      sel_awid    = m_awid[ID_W-1:0];
      sel_awaddr  = m_awaddr[ADDR_W-1:0];
      sel_awlen   = m_awlen[3:0];
      sel_awsize  = m_awsize[2:0];
      sel_awburst = m_awburst[1:0];
    end
  end

  // W channel steering: only the granted master is visible to the slave, and only in DATA.
  always_comb begin
    s_wvalid = 1'b0;
    m_wready = 2'b00;
    if (gnt) begin
      s_wdata    = m_wdata[2*DATA_W-1:DATA_W];
      s_wstrb    = m_wstrb[2*STRB_W-1:STRB_W];
      w_last_sel = m_wlast[1];
    end else begin
      s_wdata    = m_wdata[DATA_W-1:0];
      s_wstrb    = m_wstrb[STRB_W-1:0];
      w_last_sel = m_wlast[0];
    end
    if (state == DATA) begin
      s_wvalid = m_wvalid[gnt];
      if (gnt) m_wready = {s_wready, 1'b0};
      else     m_wready = {1'b0, s_wready};
    end
    s_wlast = w_last_sel;
    w_hs    = s_wvalid & s_wready;
  end

  // Next-state logic and AW handshake outputs.
  always_comb begin
    state_nxt = state;
    m_awready = 2'b00;
    s_awvalid = 1'b0;
    case (state)
      IDLE: begin
        if (aw_grant) begin
          m_awready = aw_sel ? 2'b10 : 2'b01;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        s_awvalid = 1'b1;
        if (s_awready) state_nxt = DATA;
      end
      DATA: begin
        // The transfer ends on wlast even if the beat count disagrees.
        if (w_hs && w_last_sel) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Grant bookkeeping, AW payload capture, beat counting and sticky error flag.
  always_ff @(posedge aclk) begin
    if (arst) begin
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
      cnt      <= '0;
      len      <= '0;
      err      <= 1'b0;
      aw_id    <= '0;
      aw_addr  <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
    end else begin
      if (aw_grant) begin
        last_gnt <= aw_sel;
        gnt      <= aw_sel;
        cnt      <= '0;
        len      <= sel_awlen;
        aw_id    <= {aw_sel, sel_awid};
        aw_addr  <= sel_awaddr;
        aw_size  <= sel_awsize;
        aw_burst <= sel_awburst;
      end
      if (w_hs) begin
        cnt <= cnt + 4'd1;
        if (w_last_sel != (cnt == len)) err <= 1'b1;
      end
    end
  end

  assign s_awid    = aw_id;
  assign s_awaddr  = aw_addr;
  assign s_awlen   = len;
  assign s_awsize  = aw_size;
  assign s_awburst = aw_burst;
  assign proto_err = err;

  // B path: the top ID bit names the master that issued the write.
  always_comb begin
    b_sel    = s_bid[ID_W];
    m_bvalid = {s_bvalid & b_sel, s_bvalid & ~b_sel};
    s_bready = m_bready[b_sel];
    m_bid    = s_bid[ID_W-1:0];
    m_bresp  = s_bresp;
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: grants, W steering, stall, error flag, B routing, reset.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Expected values are hand-derived per step.
module tb_axi_wr_arbiter;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic [1:0]  m_awvalid = '0;
  logic [1:0]  m_awready;
  logic [7:0]  m_awid = '0;
  logic [63:0] m_awaddr = '0;
  logic [7:0]  m_awlen = '0;
  logic [5:0]  m_awsize = '0;
  logic [3:0]  m_awburst = '0;
  logic [1:0]  m_wvalid = '0;
  logic [1:0]  m_wready;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_wstrb = '0;
  logic [1:0]  m_wlast = '0;
  logic [1:0]  m_bvalid;
  logic [1:0]  m_bready = '0;
  logic [3:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        s_awvalid;
  logic        s_awready = 1'b0;
  logic [4:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [3:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_wvalid;
  logic        s_wready = 1'b0;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid = 1'b0;
  logic        s_bready;
  logic [4:0]  s_bid = '0;
  logic [1:0]  s_bresp = '0;
  logic        proto_err;

  int n_pass  = 0;
  int n_total = 0;

  axi_wr_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .arst(arst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .proto_err(proto_err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_aw(input int m, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    m_awid[m*4 +: 4]    = id;
    m_awaddr[m*32 +: 32] = addr;
    m_awlen[m*4 +: 4]   = len;
    m_awsize[m*3 +: 3]  = 3'd2;
    m_awburst[m*2 +: 2] = 2'b01;
  endtask

  // Full transaction for master g starting in IDLE with requests already driven.
  // nbeats W beats are sent, wlast on the final one; s_awready is held low for stall cycles.
  task automatic txn(input int g, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                     input int nbeats, input int stall, input string tag);
    int          o = 1 - g;
    logic        gb = g[0];
    logic [1:0]  onehot = gb ? 2'b10 : 2'b01;
    logic [31:0] wd;
    logic [3:0]  ws;
    #1;
    chk({tag, ".idle_awvalid"}, s_awvalid, 1'b0);
    chk({tag, ".grant"}, m_awready, onehot);
    @(posedge aclk); #1;
    m_awvalid[g] = 1'b0;
    m_wvalid[g]  = 1'b1;
    s_awready    = (stall == 0);
    #1;
    chk({tag, ".awvalid"}, s_awvalid, 1'b1);
    chk({tag, ".awid"}, s_awid, {gb, id});
    chk({tag, ".awaddr"}, s_awaddr, addr);
    chk({tag, ".awlen"}, s_awlen, len);
    chk({tag, ".awready_addr"}, m_awready, 2'b00);
    chk({tag, ".wready_addr"}, m_wready, 2'b00);
    for (int i = 1; i <= stall; i++) begin
      @(posedge aclk); #1;
      if (i == stall) s_awready = 1'b1;
      #1;
      chk({tag, ".stall_awvalid"}, s_awvalid, 1'b1);
      chk({tag, ".stall_awaddr"}, s_awaddr, addr);
      chk({tag, ".stall_wready"}, {s_wvalid, m_wready}, 3'b000);
    end
    @(posedge aclk); #1;
    s_awready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      wd = 32'hD000_0000 + 32'(g * 256 + b);
      ws = 4'hF ^ 4'(b);
      m_wvalid              = 2'b11;
      m_wdata[g*32 +: 32]   = wd;
      m_wstrb[g*4 +: 4]     = ws;
      m_wlast[g]            = (b == nbeats - 1);
      m_wdata[o*32 +: 32]   = 32'hBAD0_0000;
      m_wstrb[o*4 +: 4]     = 4'h0;
      m_wlast[o]            = 1'b1;
      s_wready              = 1'b1;
      #1;
      chk({tag, ".wvalid"}, s_wvalid, 1'b1);
      chk({tag, ".wdata"}, s_wdata, wd);
      chk({tag, ".wstrb"}, s_wstrb, ws);
      chk({tag, ".wlast"}, s_wlast, (b == nbeats - 1));
      chk({tag, ".wready"}, m_wready, onehot);
      @(posedge aclk); #1;
    end
    m_wvalid = 2'b00;
    m_wlast  = 2'b00;
    s_wready = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge aclk);
    #1;
    chk("rst.awvalid", s_awvalid, 1'b0);
    chk("rst.awready", m_awready, 2'b00);
    chk("rst.wready", m_wready, 2'b00);
    chk("rst.wvalid", s_wvalid, 1'b0);
    chk("rst.proto_err", proto_err, 1'b0);
    chk("rst.awpayload", {s_awid, s_awaddr, s_awlen}, 41'd0);
    arst = 1'b0;

    // Contention after reset: m0 first, m1 after m0's wlast
    set_aw(0, 4'h5, 32'h0000_0100, 4'd3);
    set_aw(1, 4'hA, 32'h0000_0200, 4'd1);
    m_awvalid = 2'b11;
    txn(0, 4'h5, 32'h0000_0100, 4'd3, 4, 0, "cont0");
    txn(1, 4'hA, 32'h0000_0200, 4'd1, 2, 0, "cont1");
    chk("cont.proto_err", proto_err, 1'b0);

    // Single write from m0 only; FSM back in IDLE ignores further W beats
    m_awvalid = 2'b01;
    txn(0, 4'h5, 32'h0000_0100, 4'd3, 4, 0, "single");
    m_wvalid = 2'b01; s_wready = 1'b1;
    #1;
    chk("single.idle_wvalid", {s_wvalid, m_wready}, 3'b000);
    chk("single.proto_err", proto_err, 1'b0);
    m_wvalid = 2'b00; s_wready = 1'b0;

    // Fairness: continuous len-0 requests alternate, m1 first since m0 won last
    set_aw(0, 4'h1, 32'h0000_1000, 4'd0);
    set_aw(1, 4'h2, 32'h0000_2000, 4'd0);
    for (int k = 0; k < 8; k++) begin
      m_awvalid = 2'b11;
      if (k % 2 == 0) txn(1, 4'h2, 32'h0000_2000, 4'd0, 1, 0, "fair_m1");
      else            txn(0, 4'h1, 32'h0000_1000, 4'd0, 1, 0, "fair_m0");
    end
    m_awvalid = 2'b00;
    chk("fair.proto_err", proto_err, 1'b0);

    // Slave AW stall of 3 cycles
    set_aw(0, 4'h7, 32'h0000_3000, 4'd1);
    m_awvalid = 2'b01;
    txn(0, 4'h7, 32'h0000_3000, 4'd1, 2, 3, "stall");
    chk("stall.proto_err", proto_err, 1'b0);

    // Early wlast: len 3 but wlast on beat 2
    set_aw(1, 4'h3, 32'h0000_4000, 4'd3);
    m_awvalid = 2'b10;
    txn(1, 4'h3, 32'h0000_4000, 4'd3, 3, 0, "err");
    chk("err.proto_err", proto_err, 1'b1);
    set_aw(0, 4'h4, 32'h0000_5000, 4'd0);
    m_awvalid = 2'b01;
    txn(0, 4'h4, 32'h0000_5000, 4'd0, 1, 0, "sticky");
    chk("sticky.proto_err", proto_err, 1'b1);

    // B routing
    s_bvalid = 1'b1; s_bid = 5'h13; s_bresp = 2'b10; m_bready = 2'b10;
    #1;
    chk("b1.bvalid", m_bvalid, 2'b10);
    chk("b1.bid", m_bid, 4'h3);
    chk("b1.bresp", m_bresp, 2'b10);
    chk("b1.bready", s_bready, 1'b1);
    m_bready = 2'b01;
    #1;
    chk("b1.bready_low", s_bready, 1'b0);
    s_bid = 5'h07; s_bresp = 2'b00;
    #1;
    chk("b0.bvalid", m_bvalid, 2'b01);
    chk("b0.bid", m_bid, 4'h7);
    chk("b0.bready", s_bready, 1'b1);
    s_bvalid = 1'b0;
    #1;
    chk("bnone.bvalid", m_bvalid, 2'b00);
    m_bready = 2'b00;

    // Reset mid-DATA after one beat of a len-3 write
    @(posedge aclk); #1;
    set_aw(0, 4'h1, 32'h0000_0300, 4'd3);
    m_awvalid = 2'b01; s_awready = 1'b1;
    @(posedge aclk); #1;
    m_awvalid = 2'b00;
    @(posedge aclk); #1;
    s_awready = 1'b0;
    m_wvalid = 2'b01; m_wdata[31:0] = 32'h1111_0000; m_wlast = 2'b00; s_wready = 1'b1;
    #1;
    chk("mid.wready", m_wready, 2'b01);
    @(posedge aclk); #1;
    arst = 1'b1;
    @(posedge aclk); #1;
    arst = 1'b0;
    #1;
    chk("mid.rst_awvalid", s_awvalid, 1'b0);
    chk("mid.rst_ready", {m_awready, m_wready}, 4'b0000);
    chk("mid.rst_wvalid", s_wvalid, 1'b0);
    chk("mid.rst_proto_err", proto_err, 1'b0);
    m_wvalid = 2'b00; s_wready = 1'b0;

    // After reset m0 wins contention again
    set_aw(0, 4'h1, 32'h0000_0300, 4'd0);
    set_aw(1, 4'h2, 32'h0000_0400, 4'd0);
    m_awvalid = 2'b11;
    txn(0, 4'h1, 32'h0000_0300, 4'd0, 1, 0, "post0");
    txn(1, 4'h2, 32'h0000_0400, 4'd0, 1, 0, "post1");
    chk("post.proto_err", proto_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
